// File: rtl/vga_scanout_pkg.sv
// Shared definitions for the SVGA scanout stage.
//   - Default 800x600@72Hz timing constants, their totals and counter widths.
//   - Scanout FSM state type.
//   - in_window(): half-open range test used for sync pulse decoding.
package vga_scanout_pkg;

  localparam int unsigned SVGA_H_VIS  = 800;
  localparam int unsigned SVGA_H_FP   = 56;
  localparam int unsigned SVGA_H_SYNC = 120;
  localparam int unsigned SVGA_H_BP   = 64;
  localparam int unsigned SVGA_H_TOTAL = SVGA_H_VIS + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

  localparam int unsigned SVGA_V_VIS  = 600;
  localparam int unsigned SVGA_V_FP   = 37;
  localparam int unsigned SVGA_V_SYNC = 6;
  localparam int unsigned SVGA_V_BP   = 23;
  localparam int unsigned SVGA_V_TOTAL = SVGA_V_VIS + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  localparam int unsigned SVGA_HCBITS = 11;
  localparam int unsigned SVGA_VCBITS = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } scan_state_e;

  // True when lo <= pos < lo + len.
  function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO.
//   clk, rst         clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata      write request and data
//   pop              read request; ignored while empty
//   rdata            head entry, valid whenever empty is low
//   empty            no entries stored
//   count            current occupancy (ABITS+1 wide)
//   count_next       occupancy after this cycle's push/pop
module vga_pixel_fifo
  import vga_scanout_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ABITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [ABITS:0]   count,
  output logic [ABITS:0]   count_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] wr_ptr_q;
  logic [ABITS-1:0] rd_ptr_q;
  logic [ABITS:0]   count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (ABITS+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A slot freed by a same-cycle pop may be refilled.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_next = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers are ABITS wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// SVGA scanout: buffers the pipeline's pixel stream, generates sync/blank timing and drives
// the DAC pins.
//   clk, rst       pixel clock, asynchronous active-high reset
//   vg__color      pixel from the pipeline, valid LATENCY cycles after a cycle with vg__stall=0
//   vg__stall      registered back-pressure to the pipeline counters
//   vga__color     registered pixel to the DAC, 0 while blanked
//   vga__hsync     registered horizontal sync, active-high
//   vga__vsync     registered vertical sync, active-high
//   vga__blank     registered, 1 outside the visible area
//   sc__underrun   sticky flag: a pop found the FIFO empty
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned COLORBITS = 8,
  parameter int unsigned FIFODEPTH = 16,
  parameter int unsigned FIFOBITS  = 4,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned PRIME     = 8,
  parameter int unsigned H_VIS     = SVGA_H_VIS,
  parameter int unsigned H_FP      = SVGA_H_FP,
  parameter int unsigned H_SYNC    = SVGA_H_SYNC,
  parameter int unsigned H_BP      = SVGA_H_BP,
  parameter int unsigned V_VIS     = SVGA_V_VIS,
  parameter int unsigned V_FP      = SVGA_V_FP,
  parameter int unsigned V_SYNC    = SVGA_V_SYNC,
  parameter int unsigned V_BP      = SVGA_V_BP,
  parameter int unsigned HCBITS    = SVGA_HCBITS,
  parameter int unsigned VCBITS    = SVGA_VCBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLORBITS-1:0] vg__color,
  output logic                 vg__stall,
  output logic [COLORBITS-1:0] vga__color,
  output logic                 vga__hsync,
  output logic                 vga__vsync,
  output logic                 vga__blank,
  output logic                 sc__underrun
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  // Leaves room for the LATENCY pushes already in flight when stall rises.
  localparam int unsigned STALL_LEVEL = FIFODEPTH - LATENCY - 1;

  logic [LATENCY-1:0]   valid_q;
  logic                 stall_q;
  logic                 push;
  logic                 pop;
  scan_state_e          state_q;
  logic [HCBITS-1:0]    hc_q;
  logic [VCBITS-1:0]    vc_q;
  logic                 visible;
  logic                 hs_now;
  logic                 vs_now;
  logic [COLORBITS-1:0] color_q;
  logic                 hsync_q;
  logic                 vsync_q;
  logic                 blank_q;
  logic                 underrun_q;

  logic [COLORBITS-1:0] fifo_rdata;
  logic                 fifo_empty;
  logic [FIFOBITS:0]    fifo_count;
  logic [FIFOBITS:0]    fifo_count_next;

  assign push    = valid_q[LATENCY-1];
  assign visible = (state_q == StRun) && (hc_q < HCBITS'(H_VIS)) && (vc_q < VCBITS'(V_VIS));
  assign pop     = visible;
  assign hs_now  = (state_q == StRun) && in_window(32'(hc_q), H_VIS + H_FP, H_SYNC);
  assign vs_now  = (state_q == StRun) && in_window(32'(vc_q), V_VIS + V_FP, V_SYNC);

  vga_pixel_fifo #(
    .WIDTH (COLORBITS),
    .DEPTH (FIFODEPTH),
    .ABITS (FIFOBITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wdata      (vg__color),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  // Input side: track which cycles carry a pipeline pixel, and throttle the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      stall_q <= 1'b0;
    end else begin
      valid_q[0] <= ~stall_q;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      stall_q <= (fifo_count_next >= (FIFOBITS+1)'(STALL_LEVEL));
    end
  end

  // Scanout FSM, raster counters and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hc_q    <= '0;
      vc_q    <= '0;
      color_q <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          hc_q    <= '0;
          vc_q    <= '0;
          color_q <= '0;
          hsync_q <= 1'b0;
          vsync_q <= 1'b0;
          blank_q <= 1'b1;
          if (fifo_count >= (FIFOBITS+1)'(PRIME)) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (hc_q == HCBITS'(H_TOTAL - 1)) begin
            hc_q <= '0;
            vc_q <= (vc_q == VCBITS'(V_TOTAL - 1)) ? '0 : vc_q + 1'b1;
          end else begin
            hc_q <= hc_q + 1'b1;
          end
          blank_q <= ~visible;
          hsync_q <= hs_now;
          vsync_q <= vs_now;
          color_q <= (visible && !fifo_empty) ? fifo_rdata : '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
    end else if (pop && fifo_empty) begin
      underrun_q <= 1'b1;
    end
  end

  assign vg__stall    = stall_q;
  assign vga__color   = color_q;
  assign vga__hsync   = hsync_q;
  assign vga__vsync   = vsync_q;
  assign vga__blank   = blank_q;
  assign sc__underrun = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a shrunken raster so several frames fit in a short run.
// The driver plays the upstream pipeline (ramp source honouring vg__stall) and queues every
// pixel it hands over; the monitor derives raster position from elapsed cycles since the first
// visible output and pops/compares pixels, sync and blank against that position.
module tb_vga_scanout;

  localparam int H_VIS = 16, H_FP = 3, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 6,  V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int FIFODEPTH = 16, LATENCY = 1, PRIME = 8;
  localparam int STALL_LEVEL = FIFODEPTH - LATENCY - 1;
  // Edges after reset release until the first visible pixel reaches the pins.
  localparam int RUN_START = LATENCY + PRIME + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vg_color = '0;
  logic       vg__stall;
  logic [7:0] vga__color;
  logic       vga__hsync, vga__vsync, vga__blank, sc__underrun;

  int n_checks = 0;
  int n_pass = 0;

  // Driver / monitor shared state.
  bit       drv_en = 0, mon_en = 0;
  bit       pend_valid = 0;
  logic [7:0] idx = '0;
  logic [7:0] exp_q[$];
  int       cyc = 0, t = 0;
  bit       started = 0, stuck = 0;

  always #5 clk = ~clk;

  vga_scanout #(
    .COLORBITS (8),
    .FIFODEPTH (FIFODEPTH),
    .FIFOBITS  (4),
    .LATENCY   (LATENCY),
    .PRIME     (PRIME),
    .H_VIS     (H_VIS),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VIS     (V_VIS),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .HCBITS    (5),
    .VCBITS    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vg__color    (vg_color),
    .vg__stall    (vg__stall),
    .vga__color   (vga__color),
    .vga__hsync   (vga__hsync),
    .vga__vsync   (vga__vsync),
    .vga__blank   (vga__blank),
    .sc__underrun (sc__underrun)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_stall"}, vg__stall, 0);
    check({tag, "_color"}, vga__color, 0);
    check({tag, "_hsync"}, vga__hsync, 0);
    check({tag, "_vsync"}, vga__vsync, 0);
    check({tag, "_blank"}, vga__blank, 1);
    check({tag, "_underrun"}, sc__underrun, 0);
  endtask

  // Prepare the models while rst is high, then release it two units after a rising edge.
  task automatic start_run();
    exp_q.delete();
    pend_valid = 0;
    idx = 8'($urandom_range(255, 0));
    cyc = 0;
    t = 0;
    started = 0;
    stuck = 0;
    @(posedge clk);
    #2;
    rst = 0;
    drv_en = 1;
    mon_en = 1;
  endtask

  // Pipeline model: counters advance on a cycle with stall low; the pixel arrives LATENCY
  // (one) cycle later. Non-pixel cycles carry random junk that must never be stored.
  always @(negedge clk) begin
    if (!rst && drv_en) begin
      if (pend_valid) begin
        vg_color = idx;
        exp_q.push_back(idx);
        idx = idx + 8'd1;
      end else begin
        vg_color = 8'($urandom);
      end
      pend_valid = (vg__stall == 1'b0);
    end
  end

  always @(negedge clk) begin
    int  hc, vc;
    bit  vis;
    if (!rst && mon_en) begin
      if (!started && !stuck) begin
        if (!vga__blank) begin
          check("run_start_cycle", cyc, RUN_START);
          started = 1;
          t = 0;
        end else if (cyc >= RUN_START + 40) begin
          check("run_start_cycle", cyc, RUN_START);
          stuck = 1;
        end else begin
          check("idle_pins", int'({vga__hsync, vga__vsync, vga__color}), 0);
        end
      end
      if (started) begin
        hc  = t % H_TOTAL;
        vc  = (t / H_TOTAL) % V_TOTAL;
        vis = (hc < H_VIS) && (vc < V_VIS);
        check("blank", vga__blank, int'(!vis));
        check("hsync", vga__hsync, int'(hc >= H_VIS + H_FP && hc < H_VIS + H_FP + H_SYNC));
        check("vsync", vga__vsync, int'(vc >= V_VIS + V_FP && vc < V_VIS + V_FP + V_SYNC));
        if (vis) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pixel_queue: got visible pixel %0d, expected none pending", vga__color);
          end else begin
            check("pixel", vga__color, int'(exp_q.pop_front()));
          end
        end else begin
          check("blank_color", vga__color, 0);
        end
        t++;
      end
      check("stall_rule", vg__stall, int'(dut.u_fifo.count >= 5'(STALL_LEVEL)));
      check("count_bound", int'(dut.u_fifo.count <= 5'(FIFODEPTH)), 1);
      check("push_while_full", int'(dut.push && (dut.u_fifo.count == 5'(FIFODEPTH))), 0);
      check("no_underrun", sc__underrun, 0);
      cyc++;
    end
  end

  initial begin
    int  nfr, target;
    bit  ok;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("por");

    // Free-run a random number of frames, then reset mid-line.
    start_run();
    nfr = $urandom_range(3, 2);
    target = nfr * FRAME + 3 * H_TOTAL + 10;
    ok = 0;
    for (int k = 0; k < target + 200; k++) begin
      @(posedge clk);
      #2;
      if (started && t == target - 1) begin
        ok = 1;
        break;
      end
    end
    check("reached_midline_point", int'(ok), 1);
    drv_en = 0;
    mon_en = 0;
    rst = 1;
    #1;
    check_reset_pins("async_rst");
    @(posedge clk);
    #1;
    check_reset_pins("midline_rst");

    // Clean restart through IDLE.
    start_run();
    ok = 0;
    for (int k = 0; k < 2 * FRAME + 200; k++) begin
      @(posedge clk);
      #2;
      if (started && t >= FRAME + 50) begin
        ok = 1;
        break;
      end
    end
    check("restart_ran", int'(ok), 1);

    // Starve the FIFO by holding the push path low for a whole frame.
    drv_en = 0;
    mon_en = 0;
    force dut.push = 1'b0;
    repeat (FRAME) @(posedge clk);
    release dut.push;
    @(negedge clk);
    check("underrun_set", sc__underrun, 1);
    repeat (2 * H_TOTAL) @(negedge clk);
    check("underrun_sticky", sc__underrun, 1);

    @(posedge clk);
    #2;
    rst = 1;
    @(posedge clk);
    #1;
    check_reset_pins("final_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
